// File: rtl/quick_spi_modes.sv
// SPI master with per-command CPOL/CPHA, bit order and one-hot chip select.
// All lanes share sclk/cs and shift in parallel; every output is registered.
module quick_spi_modes #(
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned MAX_DATA_LENGTH = 32,
    parameter int unsigned NUM_LANES       = 1,
    parameter int unsigned NUM_CS          = 4,
    parameter int unsigned CS_SETUP_CLOCKS = 2,
    parameter int unsigned CS_HOLD_CLOCKS  = 2,
    parameter int unsigned QUIET_CLOCKS    = 4,
    localparam int unsigned CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int unsigned LW  = $clog2(MAX_DATA_LENGTH + 1),
    localparam int unsigned DW  = MAX_DATA_LENGTH * NUM_LANES
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [LW-1:0]              cmd_len_i,
    input  logic [CSW-1:0]             cmd_cs_i,
    input  logic                       cmd_cpol_i,
    input  logic                       cmd_cpha_i,
    input  logic                       cmd_lsb_first_i,
    input  logic [DW-1:0]              cmd_data_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DW-1:0]              rsp_data_o,
    output logic [MAX_DATA_LENGTH-1:0] rsp_mask_o,
    output logic                       busy_o,
    output logic                       sclk_o,
    output logic [NUM_CS-1:0]          cs_n_o,
    input  logic [NUM_LANES-1:0]       sdata_i,
    output logic [NUM_LANES-1:0]       sdata_o
);
    typedef enum logic [2:0] {StIdle, StPrep, StSetup, StShift, StHold, StRespond, StQuiet} state_e;

    localparam int unsigned H  = CLK_DIV / 2;
    localparam int unsigned CW = 16;

    state_e               state;
    logic [CW-1:0]        cnt;
    logic [LW-1:0]        len, tx_pos, rx_pos;
    logic [LW:0]          edge_cnt;
    logic [CSW-1:0]       cs_sel;
    logic                 cpha, lsb;
    logic [DW-1:0]        data;

    logic [LW-1:0]              len_clamped, tx_idx, rx_idx;
    logic [NUM_LANES-1:0]       tx_bit;
    logic [DW-1:0]              rx_next;
    logic [MAX_DATA_LENGTH-1:0] mask_next;
    logic [NUM_CS-1:0]          cs_sel_n;
    logic [LW:0]                edge_next;
    logic                       fire, leading, last_edge, do_sample, do_drive;

    assign len_clamped = (cmd_len_i > LW'(MAX_DATA_LENGTH)) ? LW'(MAX_DATA_LENGTH) : cmd_len_i;
    // Transfer position p maps to data bit p (LSB-first) or L-1-p (MSB-first).
    assign tx_idx      = lsb ? tx_pos : len - tx_pos - LW'(1);
    assign rx_idx      = lsb ? rx_pos : len - rx_pos - LW'(1);
    assign edge_next   = edge_cnt + (LW + 1)'(1);
    assign leading     = ~edge_cnt[0];
    assign last_edge   = (edge_next == {len, 1'b0});
    assign do_sample   = leading ^ cpha;
    assign do_drive    = cpha ? leading : (~leading & ~last_edge);
    assign fire        = (state == StSetup && cnt == CW'(CS_SETUP_CLOCKS - 1) && len != '0) ||
                         (state == StShift && cnt == CW'(H - 1));

    always_comb begin
        tx_bit  = '0;
        rx_next = rsp_data_o;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int i = 0; i < MAX_DATA_LENGTH; i++) begin
                if (tx_idx == LW'(i)) tx_bit[l] = data[l*MAX_DATA_LENGTH + i];
                if (rx_idx == LW'(i)) rx_next[l*MAX_DATA_LENGTH + i] = sdata_i[l];
            end
        end
    end

    always_comb begin
        mask_next = '0;
        for (int i = 0; i < MAX_DATA_LENGTH; i++) mask_next[i] = (LW'(i) < len);
    end

    // Out-of-range select leaves every line high.
    always_comb begin
        cs_sel_n = '1;
        for (int c = 0; c < NUM_CS; c++) cs_sel_n[c] = (int'(cs_sel) != c);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= StIdle;
            cnt         <= '0;
            len         <= '0;
            tx_pos      <= '0;
            rx_pos      <= '0;
            edge_cnt    <= '0;
            cs_sel      <= '0;
            cpha        <= 1'b0;
            lsb         <= 1'b0;
            data        <= '0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_mask_o  <= '0;
            busy_o      <= 1'b0;
            sclk_o      <= 1'b0;
            cs_n_o      <= '1;
            sdata_o     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        len         <= len_clamped;
                        cs_sel      <= cmd_cs_i;
                        cpha        <= cmd_cpha_i;
                        lsb         <= cmd_lsb_first_i;
                        data        <= cmd_data_i;
                        sclk_o      <= cmd_cpol_i;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        rsp_data_o  <= '0;
                        tx_pos      <= '0;
                        rx_pos      <= '0;
                        edge_cnt    <= '0;
                        cnt         <= '0;
                        state       <= StPrep;
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end
                StPrep: begin
                    cs_n_o <= cs_sel_n;
                    if (!cpha && len != '0) begin
                        sdata_o <= tx_bit;
                        tx_pos  <= tx_pos + LW'(1);
                    end
                    state <= StSetup;
                end
                StSetup: begin
                    if (cnt == CW'(CS_SETUP_CLOCKS - 1)) begin
                        cnt   <= '0;
                        state <= (len == '0) ? StHold : StShift;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StShift: begin
                    if (cnt == CW'(H - 1)) begin
                        cnt <= '0;
                        if (last_edge) state <= StHold;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StHold: begin
                    if (cnt == CW'(CS_HOLD_CLOCKS - 1)) begin
                        cnt         <= '0;
                        cs_n_o      <= '1;
                        sdata_o     <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_mask_o  <= mask_next;
                        state       <= StRespond;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StRespond: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= StQuiet;
                    end
                end
                StQuiet: begin
                    if (cnt == CW'(QUIET_CLOCKS - 1)) begin
                        cnt         <= '0;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= StIdle;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= StIdle;
            endcase

            if (fire) begin
                sclk_o   <= ~sclk_o;
                edge_cnt <= edge_next;
                if (do_sample) begin
                    rsp_data_o <= rx_next;
                    rx_pos     <= rx_pos + LW'(1);
                end
                if (do_drive) begin
                    sdata_o <= tx_bit;
                    tx_pos  <= tx_pos + LW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_quick_spi_modes.sv
// Bench for quick_spi_modes: random commands, an SPI slave model checking pin timing,
// and a response scoreboard fed at command acceptance.
`timescale 1ns/1ps
module tb_quick_spi_modes;
    localparam int DIV  = 4;
    localparam int H    = DIV / 2;
    localparam int MAXL = 32;
    localparam int NL   = 1;
    localparam int NCS  = 4;
    localparam int S    = 2;
    localparam int CH   = 2;
    localparam int Q    = 4;
    localparam int LW   = $clog2(MAXL + 1);
    localparam int CSW  = 2;
    localparam int DW   = MAXL * NL;

    typedef struct {
        int              len;
        int              cs;
        bit              cpol, cpha, lsb, loopb;
        logic [DW-1:0]   data, miso;
    } desc_t;
    typedef struct {
        logic [DW-1:0]   data;
        logic [MAXL-1:0] mask;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic [CSW-1:0] cmd_cs = '0;
    logic cmd_cpol = 1'b0, cmd_cpha = 1'b0, cmd_lsb = 1'b0;
    logic [DW-1:0] cmd_data = '0;
    logic rsp_valid, rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [MAXL-1:0] rsp_mask;
    logic busy, sclk;
    logic [NCS-1:0] cs_n;
    logic [NL-1:0] sdata_in, sdata_out, miso_drv = '0;
    bit loop_en = 1'b0;

    int errors = 0, checks = 0;
    int cyc = 0, last_acc = 0, last_hs = 0, rsp_count = 0, spi_edges = 0;
    int ready_mode = 0;  // 0 random, 1 forced low, 2 forced high
    desc_t desc_q[$];
    exp_t exp_q[$];

    assign sdata_in = loop_en ? sdata_out : miso_drv;

    quick_spi_modes #(
        .CLK_DIV(DIV), .MAX_DATA_LENGTH(MAXL), .NUM_LANES(NL), .NUM_CS(NCS),
        .CS_SETUP_CLOCKS(S), .CS_HOLD_CLOCKS(CH), .QUIET_CLOCKS(Q)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
        .cmd_cs_i(cmd_cs), .cmd_cpol_i(cmd_cpol), .cmd_cpha_i(cmd_cpha),
        .cmd_lsb_first_i(cmd_lsb), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_mask_o(rsp_mask), .busy_o(busy), .sclk_o(sclk), .cs_n_o(cs_n),
        .sdata_i(sdata_in), .sdata_o(sdata_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] v;
        for (int l = 0; l < NL; l++) v[l*MAXL +: MAXL] = $urandom;
        return v;
    endfunction

    task automatic scramble();
        cmd_len  = LW'($urandom);
        cmd_cs   = CSW'($urandom);
        cmd_cpol = 1'($urandom);
        cmd_cpha = 1'($urandom);
        cmd_lsb  = 1'($urandom);
        cmd_data = rnd();
    endtask

    task automatic send(input int len, input int cs, input bit cpol, input bit cpha,
                        input bit lsb, input bit loopb, input logic [DW-1:0] data,
                        input logic [DW-1:0] miso);
        desc_t d;
        exp_t e;
        int t = 0;
        int L;
        logic [63:0] m;
        @(negedge clk);
        cmd_len = len[LW-1:0]; cmd_cs = cs[CSW-1:0];
        cmd_cpol = cpol; cmd_cpha = cpha; cmd_lsb = lsb; cmd_data = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 5000) begin @(negedge clk); t++; end
        if (!cmd_ready) begin fail("accept_timeout"); cmd_valid = 1'b0; return; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        scramble();
        L = (len > MAXL) ? MAXL : len;
        m = (64'd1 << L) - 64'd1;
        d.len = L; d.cs = cs; d.cpol = cpol; d.cpha = cpha; d.lsb = lsb; d.loopb = loopb;
        d.data = data; d.miso = miso;
        e.mask = m[MAXL-1:0];
        for (int l = 0; l < NL; l++)
            e.data[l*MAXL +: MAXL] = (loopb ? data[l*MAXL +: MAXL] : miso[l*MAXL +: MAXL]) & e.mask;
        desc_q.push_back(d);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) fail("idle_timeout");
        repeat (2) @(negedge clk);
    endtask

    function automatic logic miso_bit(input desc_t d, input int l, input int p);
        logic [MAXL-1:0] w = d.miso[l*MAXL +: MAXL];
        return d.lsb ? w[p] : w[d.len-1-p];
    endfunction

    initial begin
        forever begin
            @(posedge clk); #2;
            rsp_ready = (ready_mode == 2) || (ready_mode == 0 && $urandom_range(3) != 0);
        end
    end

    // Response scoreboard plus handshake and acceptance timestamps.
    initial begin : rsp_mon
        logic [DW-1:0] prev_data;
        logic [MAXL-1:0] prev_mask;
        bit have_prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin have_prev = 0; continue; end
            if (cmd_valid && cmd_ready) last_acc = cyc + 1;
            if (rsp_valid) begin
                if (have_prev) begin
                    check("rsp_data_stable", rsp_data, prev_data);
                    check("rsp_mask_stable", rsp_mask, prev_mask);
                end
                if (rsp_ready) begin
                    last_hs = cyc + 1;
                    rsp_count++;
                    have_prev = 0;
                    if (exp_q.size() == 0) fail("rsp_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_mask", rsp_mask, e.mask);
                    end
                end else begin
                    have_prev = 1; prev_data = rsp_data; prev_mask = rsp_mask;
                end
            end
        end
    end

    // SPI slave: shifts MISO per mode, captures MOSI, checks edge timing on the pins.
    initial begin : spi_mon
        desc_t d;
        logic [NCS-1:0] exp_cs;
        logic [MAXL-1:0] cap [NL];
        logic prev_sclk;
        int n, edges, first, last_e, ptx, prx, dur;
        bit ivl_ok, cs_ok, aborted, lead;
        forever begin
            @(negedge clk);
            if (rst || cs_n === '1) continue;
            if (desc_q.size() == 0) begin
                fail("spi_unexpected_cs");
                n = 0;
                while (cs_n !== '1 && !rst && n < 5000) begin @(negedge clk); n++; end
                continue;
            end
            d = desc_q.pop_front();
            loop_en = d.loopb;
            exp_cs = '1;
            if (d.cs < NCS) exp_cs[d.cs] = 1'b0;
            check("cs_pattern", cs_n, exp_cs);
            check("sclk_idle_at_cs", sclk, d.cpol);
            for (int l = 0; l < NL; l++) cap[l] = '0;
            n = 0; edges = 0; first = -1; last_e = 0; ptx = 0; prx = 0;
            ivl_ok = 1; cs_ok = 1; aborted = 0; prev_sclk = sclk;
            if (!d.cpha && d.len > 0) begin
                for (int l = 0; l < NL; l++) miso_drv[l] = miso_bit(d, l, 0);
                ptx = 1;
            end
            forever begin
                @(negedge clk);
                n++;
                if (rst) begin aborted = 1; break; end
                if (cs_n === '1) break;
                if (n > 5000) begin fail("spi_cs_timeout"); aborted = 1; break; end
                if (cs_n !== exp_cs) cs_ok = 0;
                if (sclk !== prev_sclk) begin
                    edges++;
                    spi_edges = edges;
                    prev_sclk = sclk;
                    if (edges == 1) first = n;
                    else if (n - last_e != H) ivl_ok = 0;
                    last_e = n;
                    lead = (edges % 2) == 1;
                    if (lead ^ d.cpha) begin
                        for (int l = 0; l < NL; l++) begin
                            if (d.lsb) cap[l][prx] = sdata_out[l];
                            else cap[l] = {cap[l][MAXL-2:0], sdata_out[l]};
                        end
                        prx++;
                    end else if (ptx < d.len) begin
                        for (int l = 0; l < NL; l++) miso_drv[l] = miso_bit(d, l, ptx);
                        ptx++;
                    end
                end
            end
            miso_drv = '0;
            spi_edges = 0;
            if (!aborted) begin
                dur = (d.len > 0) ? S + (2*d.len - 1)*H + CH : S + CH;
                check("sclk_edges", edges, 2*d.len);
                if (d.len > 0) check("first_edge_delay", first, S);
                check("edge_spacing", ivl_ok, 1);
                check("cs_steady", cs_ok, 1);
                check("cs_low_clocks", n, dur);
                check("sclk_idle_after", sclk, d.cpol);
                check("mosi_zero_after_cs", sdata_out, '0);
                for (int l = 0; l < NL; l++)
                    check("mosi_word", cap[l], d.data[l*MAXL +: MAXL] & exp_q_mask(d.len));
            end
        end
    end

    function automatic logic [MAXL-1:0] exp_q_mask(input int L);
        logic [63:0] m = (64'd1 << L) - 64'd1;
        return m[MAXL-1:0];
    endfunction

    initial begin : main
        int t, cnt0;
        #1 rst = 1'b1;
        #2;
        check("rst_ready", cmd_ready, 0);
        check("rst_cs", cs_n, 4'b1111);
        check("rst_sclk", sclk, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mosi", sdata_out, 0);
        check("rst_data", rsp_data, 0);
        check("rst_mask", rsp_mask, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", cmd_ready, 1);
        check("cs_after_rst", cs_n, 4'b1111);
        check("sclk_after_rst", sclk, 0);
        check("valid_after_rst", rsp_valid, 0);

        send(8, 2, 0, 0, 0, 1, DW'(32'hA5), '0);
        wait_idle();
        send(5, 0, 1, 1, 1, 0, DW'(32'h13), DW'(32'h13));
        wait_idle();
        send(0, 3, 0, 1, 0, 0, rnd(), rnd());
        wait_idle();
        send(40, 1, 1, 0, 0, 1, rnd(), rnd());
        wait_idle();

        // Response stall, then a command already waiting when the handshake happens.
        ready_mode = 1;
        send(12, 1, 0, 1, 0, 0, rnd(), rnd());
        t = 0;
        while (!rsp_valid && t < 2000) begin @(negedge clk); t++; end
        if (!rsp_valid) fail("stall_rsp_timeout");
        repeat (20) @(negedge clk);
        check("stall_valid_held", rsp_valid, 1);
        check("stall_busy", busy, 1);
        ready_mode = 2;
        send(7, 0, 1, 0, 1, 1, rnd(), rnd());
        check("b2b_gap", last_acc - last_hs, Q + 1);
        wait_idle();
        ready_mode = 0;

        for (int i = 0; i < 30; i++)
            send($urandom_range(40), $urandom_range(NCS - 1), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), rnd(), rnd());
        wait_idle();

        // Reset mid-SHIFT around bit 3.
        send(16, $urandom_range(NCS - 1), 1'($urandom), 1'($urandom), 1'($urandom), 0,
             rnd(), rnd());
        t = 0;
        while (spi_edges < 6 && t < 2000) begin @(negedge clk); t++; end
        if (spi_edges < 6) fail("abort_reach_timeout");
        cnt0 = rsp_count;
        #1 rst = 1'b1;
        #1;
        check("abort_cs", cs_n, 4'b1111);
        check("abort_sclk", sclk, 0);
        check("abort_valid", rsp_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 0);
        exp_q.delete();
        desc_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_after", cmd_ready, 1);
        repeat (30) @(negedge clk);
        check("abort_no_rsp", rsp_count, cnt0);
        send(9, 2, 0, 0, 0, 0, rnd(), rnd());
        wait_idle();
        send(32, 3, 1, 1, 0, 0, rnd(), rnd());
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/quick_spi_modes.md
Name: quick_spi_modes

Overview:
Parametrised SPI master for the quick_spi family. Adds per-transaction SPI mode (CPOL/CPHA), MSB/LSB-first ordering and multiple one-hot chip selects, with up to NUM_LANES devices in parallel on a shared sclk/cs. Sits between fabric logic (valid/ready command and response streams) and external SPI pins. Timing is specified in system clocks, not seconds.

Parameters:
CLK_DIV, 4, system clocks per sclk period; even, >=4; half period H = CLK_DIV/2
MAX_DATA_LENGTH, 32, maximum bits per transaction
NUM_LANES, 1, parallel devices sharing sclk/cs, each with its own sdata pair
NUM_CS, 4, number of chip-select lines; CSW = max(1,$clog2(NUM_CS))
CS_SETUP_CLOCKS, 2, clocks from cs_n fall to first sclk edge (>=1)
CS_HOLD_CLOCKS, 2, clocks from last sclk edge to cs_n rise (>=1)
QUIET_CLOCKS, 4, minimum clocks cs_n high between transactions (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready
cmd_len_i  in  $clog2(MAX_DATA_LENGTH+1)  bit count L, 0..MAX_DATA_LENGTH
cmd_cs_i  in  CSW  chip-select index
cmd_cpol_i  in  1  sclk idle level
cmd_cpha_i  in  1  0: sample leading edge; 1: sample trailing edge
cmd_lsb_first_i  in  1  bit order
cmd_data_i  in  MAX_DATA_LENGTH*NUM_LANES  write data, lane k at [k*MAX_DATA_LENGTH +: MAX_DATA_LENGTH], right-justified
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_data_o  out  MAX_DATA_LENGTH*NUM_LANES  read data, same packing, right-justified
rsp_mask_o  out  MAX_DATA_LENGTH  low L bits set
busy_o  out  1  high in every state except IDLE
sclk_o  out  1  SPI clock
cs_n_o  out  NUM_CS  active-low chip selects, at most one low
sdata_i  in  NUM_LANES  MISO per lane
sdata_o  out  NUM_LANES  MOSI per lane

Behaviour:
- One clock domain. rst_i is asynchronous and active-high. While asserted: state=IDLE, cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_mask_o=0, sclk_o=0, cs_n_o=all 1, sdata_o=0, busy_o=0. cmd_ready_o goes to 1 on the first clock edge after release.
- Reset mid-transaction aborts immediately. No response is produced.
- All outputs are registered.
- States: IDLE, PREP, SETUP, SHIFT, HOLD, RESPOND, QUIET.
- IDLE: cmd_ready_o=1. Accept when cmd_valid_i && cmd_ready_o at edge N. Latch all cmd_* fields. cmd_ready_o=0 from N+1.
- PREP, 1 clock: sclk_o=cpol from N+1. Load first MOSI bit.
- SETUP: cs_n_o[cmd_cs] low from N+2. Hold CS_SETUP_CLOCKS clocks. If cmd_cs>=NUM_CS, no line goes low, but the transaction still runs. If L=0, go straight to HOLD; no sclk edges occur.
- SHIFT: 2L sclk edges, H clocks apart. The first edge (leading, sclk_o=!cpol) is at N+2+CS_SETUP_CLOCKS.
- CPHA=0: bit 0 is driven before the first edge. Sample on leading edges. sdata_o advances on trailing edges, except after the last one.
- CPHA=1: sdata_o advances on leading edges (the first drives bit 0). Sample on trailing edges.
- SHIFT ends at the 2L-th edge; sclk_o is then back at cpol.
- Ordering, MSB-first: transmit data[L-1] down to data[0]. First sampled bit lands at rsp bit L-1.
- Ordering, LSB-first: transmit data[0] upward. First sampled bit lands at bit 0.
- Bits >= L of rsp_data_o are 0.
- HOLD: CS_HOLD_CLOCKS clocks, then cs_n_o all 1. sdata_o holds the last bit until cs_n rises, then 0.
- RESPOND: rsp_valid_o=1. rsp_data_o and rsp_mask_o are stable until rsp_valid_o && rsp_ready_i. rsp_mask_o = (1<<L)-1, L=MAX gives all ones.
- QUIET: QUIET_CLOCKS clocks, then IDLE. cs_n_o stays all 1. sclk_o keeps the last cpol until the next PREP.
- Back-to-back: earliest next acceptance is QUIET_CLOCKS+1 clocks after the response handshake.
- Length: cmd_len_i > MAX_DATA_LENGTH is clamped to MAX_DATA_LENGTH.
- Inputs are ignored outside IDLE, and cmd_* may change freely after acceptance.

Test Plan:
- Reset release, no command -> cmd_ready_o=1 at first edge, cs_n_o=4'b1111, sclk_o=0, rsp_valid_o=0.
- Mode 0, MSB-first, L=8, data=0xA5, cs=2, sdata_i looped to sdata_o -> MOSI 1,0,1,0,0,1,0,1 valid at rising edges; 16 sclk edges; cs_n_o=4'b1011; rsp_data_o=0xA5; rsp_mask_o=0x000000FF.
- Mode 3, LSB-first, L=5, data=0x13, MISO driven 1,1,0,0,1 -> sclk idles high; MOSI 1,1,0,0,1 sampled on rising edges; rsp_data_o=0x13.
- L=0 -> no sclk edges; cs low for CS_SETUP_CLOCKS+CS_HOLD_CLOCKS; rsp_mask_o=0; rsp_data_o=0.
- rsp_ready_i held low 20 clocks, then cmd_valid_i held high -> rsp_valid_o and data stable for 20 clocks; next acceptance exactly QUIET_CLOCKS+1 clocks after handshake.
- rst_i asserted mid-SHIFT at bit 3 -> same cycle cs_n_o=all 1, sclk_o=0, no response; a new transaction completes correctly after release.
